// File: rtl/uart_tx_arbiter_if.sv
//------------------------------------------------------------------------------
// Module   : uart_tx_arbiter_if
// Brief    : Requester-side valid/ready byte bus for the shared UART transmitter.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_ready;

    modport master (
        output req_valid,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready
    );
endinterface

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
//------------------------------------------------------------------------------
// Module   : uart_tx_arbiter
// Brief    : Round-robin arbiter feeding an 8N1 serializer on the shared uart_rx pin.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx_arbiter #(
    parameter int N_REQ  = 4,
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 115200
) (
    input  wire logic                     gclk,
    input  wire logic                     rst_n,
    uart_tx_arbiter_if.slave              req_if,
    output logic                          uart_rx,
    output logic                          busy,
    output logic [$clog2(N_REQ)-1:0]      grant_id
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int ID_W         = $clog2(N_REQ);
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [ID_W-1:0]  LAST_RESET = ID_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  baud_q,  baud_d;
    logic [2:0]        bit_q,   bit_d;
    logic [7:0]        data_q,  data_d;
    logic [ID_W-1:0]   last_q,  last_d;
    logic [ID_W-1:0]   grant_q, grant_d;

    logic              found;
    logic [ID_W-1:0]   win;
    logic [N_REQ-1:0]  ready;
    logic              baud_done;

    // Search upward from the requester after the last grant, wrapping once.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            int idx;
            idx = (int'(last_q) + off) % N_REQ;
            if (!found && req_if.req_valid[idx]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end
    end

    assign baud_done = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 1'b1;
        bit_d   = bit_q;
        data_d  = data_q;
        last_d  = last_q;
        grant_d = grant_q;
        ready   = '0;

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                // rst_n gating keeps the accept pulse low while reset is held.
                if (found && rst_n) begin
                    ready[win] = 1'b1;
                    data_d     = req_if.req_data[8*int'(win) +: 8];
                    last_d     = win;
                    grant_d    = win;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                baud_d  = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge gclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            last_q  <= LAST_RESET;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            last_q  <= last_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        uart_rx = 1'b1;
        case (state_q)
            S_START: uart_rx = 1'b0;
            S_DATA:  uart_rx = data_q[bit_q];
            default: uart_rx = 1'b1;
        endcase
    end

    assign busy             = (state_q != S_IDLE);
    assign grant_id         = grant_q;
    assign req_if.req_ready = ready;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_uart_tx_arbiter
// Brief    : Randomized self-checking bench with a round-robin/frame reference model.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int CPB = 8;
    localparam int FL  = 10 * CPB;

    logic       gclk;
    logic       rst_n;
    logic       uart_rx;
    logic       busy;
    logic [1:0] grant_id;

    int checks = 0;
    int passed = 0;
    int m_last = N - 1;

    uart_tx_arbiter_if #(.N_REQ(N)) bus ();

    uart_tx_arbiter #(.N_REQ(N), .CLK_HZ(8), .BAUD(1)) dut (
        .gclk     (gclk),
        .rst_n    (rst_n),
        .req_if   (bus.slave),
        .uart_rx  (uart_rx),
        .busy     (busy),
        .grant_id (grant_id)
    );

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    function automatic int rr_pick(input int last, input logic [N-1:0] v);
        for (int off = 1; off <= N; off++) begin
            if (v[(last + off) % N]) return (last + off) % N;
        end
        return -1;
    endfunction

    // Expected line level for every cycle of a frame: start, 8 data bits LSB first, stop.
    function automatic logic [FL-1:0] frame_bits(input logic [7:0] b);
        logic [FL-1:0] f;
        for (int k = 0; k < FL; k++) begin
            int slot;
            slot = k / CPB;
            if (slot == 0)      f[k] = 1'b0;
            else if (slot == 9) f[k] = 1'b1;
            else                f[k] = b[slot-1];
        end
        return f;
    endfunction

    task automatic apply_reset();
        bus.req_valid = '0;
        bus.req_data  = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge gclk);
        rst_n  = 1'b1;
        m_last = N - 1;
    endtask

    // Waits for a grant, checks it against the model, then records the whole frame.
    task automatic serve(input string name, input bit keep, input int ev_on, input int ev_off,
                         input logic [N-1:0] ev_mask, input int abort_at,
                         output int obs_w, output int waited, output logic [FL-1:0] line);
        int            exp_w;
        logic [N-1:0]  exp_oh;
        logic [7:0]    sent;
        logic [7:0]    nb;
        logic [FL-1:0] exp_line;
        bit            busy_all;
        bit            ready_any;
        logic [1:0]    gid;
        waited = 0;
        obs_w  = -1;
        line   = '0;
        #1;
        while (bus.req_ready === '0 && waited < 300) begin
            @(negedge gclk);
            #1;
            waited++;
        end
        checks++;
        if (bus.req_ready === '0) begin
            $display("FAIL %s grant_wait: no req_ready within %0d cycles, valid=%b", name, waited, bus.req_valid);
            return;
        end
        passed++;
        for (int i = 0; i < N; i++) if (bus.req_ready[i]) obs_w = i;
        exp_w  = rr_pick(m_last, bus.req_valid);
        exp_oh = (exp_w >= 0) ? (N'(1) << exp_w) : '0;
        checks++;
        if (bus.req_ready !== exp_oh)
            $display("FAIL %s req_ready: got %b expected %b (valid=%b)", name, bus.req_ready, exp_oh, bus.req_valid);
        else passed++;
        if (exp_w < 0) return;
        m_last = exp_w;
        sent   = bus.req_data[8*exp_w +: 8];
        @(posedge gclk);
        #1;
        nb = 8'($urandom);
        if (nb == sent) nb = ~sent;
        bus.req_data[8*exp_w +: 8] = nb;
        if (!keep) bus.req_valid[exp_w] = 1'b0;
        busy_all  = 1'b1;
        ready_any = 1'b0;
        gid       = '0;
        for (int k = 0; k < FL; k++) begin
            @(negedge gclk);
            line[k] = uart_rx;
            if (busy !== 1'b1) busy_all = 1'b0;
            if (bus.req_ready !== '0) ready_any = 1'b1;
            if (k == 0) gid = grant_id;
            if (k == abort_at) begin
                bus.req_valid = '1;
                #2 rst_n = 1'b0;
                #1;
                checks++;
                if (uart_rx !== 1'b1) $display("FAIL %s abort_uart_rx: got %b expected 1", name, uart_rx);
                else passed++;
                checks++;
                if (busy !== 1'b0) $display("FAIL %s abort_busy: got %b expected 0", name, busy);
                else passed++;
                checks++;
                if (bus.req_ready !== '0) $display("FAIL %s abort_req_ready: got %b expected 0000", name, bus.req_ready);
                else passed++;
                m_last = N - 1;
                @(negedge gclk);
                rst_n = 1'b1;
                return;
            end
            if (k == ev_on)  bus.req_valid = bus.req_valid | ev_mask;
            if (k == ev_off) bus.req_valid = bus.req_valid & ~ev_mask;
        end
        exp_line = frame_bits(sent);
        checks++;
        if (line !== exp_line) $display("FAIL %s line: byte %h got %h expected %h", name, sent, line, exp_line);
        else passed++;
        checks++;
        if (!busy_all) $display("FAIL %s busy_in_frame: got low expected high for %0d cycles", name, FL);
        else passed++;
        checks++;
        if (ready_any) $display("FAIL %s ready_in_frame: got pulse expected none", name);
        else passed++;
        checks++;
        if (int'(gid) != exp_w) $display("FAIL %s grant_id: got %0d expected %0d", name, gid, exp_w);
        else passed++;
        @(negedge gclk);
        checks++;
        if (uart_rx !== 1'b1 || busy !== 1'b0)
            $display("FAIL %s idle_after_frame: got rx=%b busy=%b expected rx=1 busy=0", name, uart_rx, busy);
        else passed++;
    endtask

    task automatic test_reset();
        bus.req_valid = '1;
        bus.req_data  = '0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (uart_rx !== 1'b1 || busy !== 1'b0 || bus.req_ready !== '0 || grant_id !== 2'd0)
            $display("FAIL reset: got rx=%b busy=%b ready=%b gid=%0d expected 1 0 0000 0",
                     uart_rx, busy, bus.req_ready, grant_id);
        else passed++;
        apply_reset();
    endtask

    task automatic test_single();
        int w, wt;
        logic [FL-1:0] ln;
        apply_reset();
        bus.req_data[23:16] = 8'hA5;
        bus.req_valid       = 4'b0100;
        serve("single", 1'b0, -1, -1, '0, -1, w, wt, ln);
        checks++;
        if (w != 2) $display("FAIL single_winner: got %0d expected 2", w);
        else passed++;
    endtask

    task automatic test_all_valid();
        int w, wt;
        logic [FL-1:0] ln;
        int exp_order [6] = '{0, 1, 2, 3, 0, 1};
        apply_reset();
        bus.req_data  = 32'($urandom);
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            serve("all_valid", 1'b1, -1, -1, '0, -1, w, wt, ln);
            checks++;
            if (w != exp_order[i]) $display("FAIL all_valid_order[%0d]: got %0d expected %0d", i, w, exp_order[i]);
            else passed++;
            if (i > 0) begin
                checks++;
                if (wt != 0) $display("FAIL all_valid_gap[%0d]: got %0d extra idle cycles expected 0", i, wt);
                else passed++;
            end
        end
    endtask

    task automatic test_alternate();
        int w, wt;
        logic [FL-1:0] ln;
        apply_reset();
        bus.req_data  = 32'($urandom);
        bus.req_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            serve("alternate", 1'b1, -1, -1, '0, -1, w, wt, ln);
            checks++;
            if (w != ((i % 2 == 0) ? 1 : 3)) $display("FAIL alternate_order[%0d]: got %0d expected %0d", i, w, (i % 2 == 0) ? 1 : 3);
            else passed++;
        end
    endtask

    task automatic test_mid_reset();
        int w, wt;
        logic [FL-1:0] ln;
        apply_reset();
        bus.req_data  = 32'($urandom);
        bus.req_valid = 4'b0001;
        serve("mid_reset", 1'b0, -1, -1, '0, 40, w, wt, ln);
        bus.req_valid = 4'b1111;
        serve("after_reset", 1'b0, -1, -1, '0, -1, w, wt, ln);
        checks++;
        if (w != 0) $display("FAIL after_reset_winner: got %0d expected 0", w);
        else passed++;
    endtask

    task automatic test_drop_and_latch();
        int w, wt;
        logic [FL-1:0] ln;
        bit extra;
        apply_reset();
        bus.req_data  = 32'($urandom);
        bus.req_valid = 4'b0001;
        serve("drop_latch", 1'b0, 20, 60, 4'b1000, -1, w, wt, ln);
        extra = 1'b0;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (bus.req_ready !== '0 || busy !== 1'b0) extra = 1'b1;
            @(negedge gclk);
        end
        checks++;
        if (extra) $display("FAIL drop_no_extra: got a grant or frame expected none");
        else passed++;
    endtask

    task automatic test_boundary();
        int w, wt, lows, highs;
        logic [FL-1:0] ln;
        logic [7:0] vals [2] = '{8'h00, 8'hFF};
        for (int v = 0; v < 2; v++) begin
            apply_reset();
            bus.req_data[7:0] = vals[v];
            bus.req_valid     = 4'b0001;
            serve("boundary", 1'b0, -1, -1, '0, -1, w, wt, ln);
            lows = 0;
            while (lows < FL && ln[lows] == 1'b0) lows++;
            highs = 0;
            while (lows + highs < FL && ln[lows + highs] == 1'b1) highs++;
            checks++;
            if (lows != ((v == 0) ? 72 : 8) || highs != ((v == 0) ? 8 : 72))
                $display("FAIL boundary_%h: got low=%0d high=%0d expected low=%0d high=%0d",
                         vals[v], lows, highs, (v == 0) ? 72 : 8, (v == 0) ? 8 : 72);
            else passed++;
        end
    endtask

    task automatic test_random();
        int w, wt;
        logic [FL-1:0] ln;
        apply_reset();
        bus.req_data = $urandom;
        for (int r = 0; r < 10; r++) begin
            bus.req_valid = 4'($urandom_range(1, 15));
            serve("random", 1'($urandom), -1, -1, '0, -1, w, wt, ln);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        test_reset();
        test_single();
        test_all_valid();
        test_alternate();
        test_mid_reset();
        test_drop_and_latch();
        test_boundary();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
